// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   - state encoding for the sequencer FSM
//   - constant helpers used to size counters at elaboration time
package reset_seq_pkg;

    localparam logic [1:0] ENC_HOLD    = 2'd0;
    localparam logic [1:0] ENC_STRETCH = 2'd1;
    localparam logic [1:0] ENC_RELEASE = 2'd2;
    localparam logic [1:0] ENC_RUN     = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD    = ENC_HOLD,
        ST_STRETCH = ENC_STRETCH,
        ST_RELEASE = ENC_RELEASE,
        ST_RUN     = ENC_RUN
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_flops.sv
// sync_flops: plain flop chain for bringing a level signal into the clk domain.
//   clk   : destination clock
//   srst  : synchronous active-high reset, loads every stage with INIT
//   d     : asynchronous level input
//   q     : synchronised output (last stage)
module sync_flops #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) stage_reg[gi] <= INIT;
                    else      stage_reg[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (srst) stage_reg[gi] <= INIT;
                    else      stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: produces CHANNELS ordered reset outputs. All pending
// channels are held for STRETCH cycles, then released one at a time every
// STEP cycles, channel 0 first. An external async request restarts the whole
// sequence; a per-channel soft reset restarts from the lowest requested
// channel that is already released.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   rst_req_async : asynchronous active-high external reset request
//   sw_rst        : per-channel soft-reset request (pulse or level)
//   rst_out       : active-high registered reset per channel
//   ready         : registered, high once every channel is released
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int STEP        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_req_async,
    input  logic [CHANNELS-1:0] sw_rst,
    output logic [CHANNELS-1:0] rst_out,
    output logic                ready
);

    localparam int CNT_W = clog2(max_int(STRETCH, STEP) + 1);
    localparam int IDX_W = clog2(CHANNELS + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP - 1);
    localparam logic [IDX_W-1:0] IDX_DONE     = IDX_W'(CHANNELS);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("reset_sequencer: CHANNELS must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("reset_sequencer: SYNC_STAGES must be >= 2");
        end
        if (STRETCH < 1) begin : g_bad_stretch
            $error("reset_sequencer: STRETCH must be >= 1");
        end
        if (STEP < 1) begin : g_bad_step
            $error("reset_sequencer: STEP must be >= 1");
        end
    endgenerate

    // Index of the lowest set bit; CHANNELS when none is set, which can never
    // be below idx and so never triggers a restart.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [CHANNELS-1:0] v);
        logic [IDX_W-1:0] result;
        result = IDX_DONE;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) result = IDX_W'(i);
        end
        return result;
    endfunction

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [CHANNELS-1:0] rst_out_reg, rst_out_next;
    logic                ready_reg, ready_next;
    logic                req_sync;
    logic [IDX_W-1:0]    sw_k;
    logic [IDX_W-1:0]    idx_inc;

    // Reset loads the chain with ones so a request is assumed pending until
    // the synchroniser has flushed real input samples through.
    sync_flops #(
        .STAGES (SYNC_STAGES),
        .INIT   (1'b1)
    ) u_req_sync (
        .clk  (clk),
        .srst (rst),
        .d    (rst_req_async),
        .q    (req_sync)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        sw_k       = lowest_set(sw_rst);
        idx_inc    = idx_reg + IDX_W'(1);

        if (rst || req_sync) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    state_next = ST_STRETCH;
                    cnt_next   = '0;
                end
                ST_STRETCH: begin
                    if (cnt_reg == STRETCH_LAST) begin
                        cnt_next   = '0;
                        idx_next   = idx_inc;
                        state_next = (idx_inc == IDX_DONE) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (sw_k < idx_reg) begin
                        // Re-assert from the lowest already-released requester.
                        idx_next   = sw_k;
                        cnt_next   = '0;
                        state_next = ST_STRETCH;
                    end else if (cnt_reg == STEP_LAST) begin
                        cnt_next = '0;
                        idx_next = idx_inc;
                        if (idx_inc == IDX_DONE) state_next = ST_RUN;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_k < idx_reg) begin
                        idx_next   = sw_k;
                        cnt_next   = '0;
                        state_next = ST_STRETCH;
                    end
                end
                default: begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end

        ready_next = (state_next == ST_RUN);
    end

    // Channel j stays in reset while it has not yet been released.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_out
            assign rst_out_next[gi] = (IDX_W'(gi) >= idx_next);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_HOLD;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            rst_out_reg <= rst_out_next;
            ready_reg   <= ready_next;
        end
    end

    assign rst_out = rst_out_reg;
    assign ready   = ready_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int ST = 16;
    localparam int SP = 8;

    logic          clk;
    logic          rst;
    logic          rst_req_async;
    logic [CH-1:0] sw_rst;
    logic [CH-1:0] rst_out;
    logic          ready;

    int vectors    = 0;
    int miscompares = 0;

    reset_sequencer #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .STRETCH     (ST),
        .STEP        (SP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rst_req_async (rst_req_async),
        .sw_rst        (sw_rst),
        .rst_out       (rst_out),
        .ready         (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // A sequence is described by the edge t0 on which stretching began and
    // the first channel base it re-sequences. Channels below base are free;
    // channel base+i is free from edge t0 + ST + SP*i onward.
    logic [SS-1:0] sync_q = '1;
    bit            m_hold = 1'b1;
    int            m_t0   = 0;
    int            m_base = 0;
    int            n      = 0;
    bit            check_en = 1'b1;

    function automatic int rel(input int m);
        int r;
        if (m < m_t0 + ST) return m_base;
        r = m_base + (m - m_t0 - ST) / SP + 1;
        return (r > CH) ? CH : r;
    endfunction

    function automatic int lowest(input logic [CH-1:0] v);
        for (int i = 0; i < CH; i++) begin
            if (v[i]) return i;
        end
        return CH;
    endfunction

    always begin : compare_proc
        logic          req_now;
        int            k;
        int            idx_prev;
        int            idx_now;
        logic [CH-1:0] exp_out;
        logic          exp_ready;
        @(posedge clk);
        req_now = sync_q[SS-1];
        if (rst) sync_q = '1;
        else     sync_q = {sync_q[SS-2:0], rst_req_async};
        k = lowest(sw_rst);
        if (rst || req_now) begin
            m_hold = 1'b1;
        end else if (m_hold) begin
            m_hold = 1'b0;
            m_t0   = n;
            m_base = 0;
        end else begin
            idx_prev = rel(n - 1);
            // Soft resets count only once releasing has begun.
            if ((n - 1 >= m_t0 + ST) && (k < idx_prev)) begin
                m_base = k;
                m_t0   = n;
            end
        end
        idx_now = m_hold ? 0 : rel(n);
        for (int j = 0; j < CH; j++) exp_out[j] = m_hold || (j >= idx_now);
        exp_ready = !m_hold && (idx_now == CH);
        #1;
        if (check_en) begin
            vectors++;
            if (rst_out !== exp_out || ready !== exp_ready) begin
                miscompares++;
                $display("FAIL model edge %0d: rst_out=%b ready=%b, required rst_out=%b ready=%b",
                         n, rst_out, ready, exp_out, exp_ready);
            end
        end
        n++;
    end

    // ---------------- directed literal checks ----------------
    task automatic tick_n(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [CH-1:0] exp_out, input logic exp_ready);
        vectors++;
        if (rst_out !== exp_out || ready !== exp_ready) begin
            miscompares++;
            $display("FAIL %s: rst_out=%b ready=%b, required rst_out=%b ready=%b",
                     name, rst_out, ready, exp_out, exp_ready);
        end else begin
            $display("check %-14s rst_out=%b ready=%b", name, rst_out, ready);
        end
    endtask

    initial begin : stim
        int async_left;
        int sw_left;
        logic [CH-1:0] sw_val;

        rst = 1'b1;
        rst_req_async = 1'b0;
        sw_rst = '0;

        // Power-on: E0 is the third edge after rst drops (sync chain flush).
        tick_n(5);
        chk("reset", 4'b1111, 1'b0);
        rst = 1'b0;
        tick_n(3);
        chk("por_e0", 4'b1111, 1'b0);
        tick_n(15);
        chk("por_e0+15", 4'b1111, 1'b0);
        tick_n(1);
        chk("por_e0+16", 4'b1110, 1'b0);
        tick_n(8);
        chk("por_e0+24", 4'b1100, 1'b0);
        tick_n(8);
        chk("por_e0+32", 4'b1000, 1'b0);
        tick_n(8);
        chk("por_e0+40", 4'b0000, 1'b1);

        // External request for 3 cycles.
        rst_req_async = 1'b1;
        tick_n(2);
        chk("async_2nd", 4'b0000, 1'b1);
        tick_n(1);
        chk("async_3rd", 4'b1111, 1'b0);
        rst_req_async = 1'b0;
        tick_n(3);
        tick_n(15);
        chk("async_e0+15", 4'b1111, 1'b0);
        tick_n(1);
        chk("async_e0+16", 4'b1110, 1'b0);
        tick_n(24);
        chk("async_run", 4'b0000, 1'b1);

        // Soft reset of channel 2.
        sw_rst = 4'b0100;
        tick_n(1);
        sw_rst = '0;
        chk("sw2_edge", 4'b1100, 1'b0);
        tick_n(15);
        chk("sw2_+15", 4'b1100, 1'b0);
        tick_n(1);
        chk("sw2_+16", 4'b1000, 1'b0);
        tick_n(8);
        chk("sw2_+24", 4'b0000, 1'b1);

        // Two requesters: channel 1 wins.
        sw_rst = 4'b1010;
        tick_n(1);
        sw_rst = '0;
        chk("sw13_edge", 4'b1110, 1'b0);
        tick_n(16);
        chk("sw13_+16", 4'b1100, 1'b0);
        tick_n(8);
        chk("sw13_+24", 4'b1000, 1'b0);
        tick_n(8);
        chk("sw13_+32", 4'b0000, 1'b1);

        // Get to RELEASE with idx=2, then poke it.
        sw_rst = 4'b0001;
        tick_n(1);
        sw_rst = '0;
        chk("sw0_edge", 4'b1111, 1'b0);
        tick_n(24);
        chk("rel_idx2", 4'b1100, 1'b0);
        sw_rst = 4'b1000;
        tick_n(1);
        chk("sw3_ignored", 4'b1100, 1'b0);
        sw_rst = 4'b0001;
        tick_n(1);
        sw_rst = '0;
        chk("sw0_restart", 4'b1111, 1'b0);
        tick_n(15);
        chk("sw0r_+15", 4'b1111, 1'b0);
        tick_n(1);
        chk("sw0r_+16", 4'b1110, 1'b0);
        tick_n(16);
        chk("rel_idx3", 4'b1000, 1'b0);

        // One-cycle rst mid-RELEASE.
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        chk("rst_mid", 4'b1111, 1'b0);
        tick_n(3);
        tick_n(15);
        chk("rst_e0+15", 4'b1111, 1'b0);
        tick_n(1);
        chk("rst_e0+16", 4'b1110, 1'b0);

        // Randomised phase: model checks every edge.
        async_left = 0;
        sw_left    = 0;
        sw_val     = '0;
        for (int c = 0; c < 5000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (async_left > 0) begin
                rst_req_async = 1'b1;
                async_left--;
            end else begin
                rst_req_async = 1'b0;
                if ($urandom_range(0, 199) == 0) async_left = $urandom_range(1, 6);
            end
            if (sw_left > 0) begin
                sw_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                sw_val  = CH'($urandom_range(1, (1 << CH) - 1));
                sw_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            end else begin
                sw_val = '0;
            end
            sw_rst = sw_val;
            tick_n(1);
        end
        rst = 1'b0;
        rst_req_async = 1'b0;
        sw_rst = '0;
        tick_n(2);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
